// File: rtl/mont_domain_encoder.sv
// Serial Montgomery-domain encoder: result_o = y_i * 2^k mod m_i, k = m_bl_i.
// One shift-and-reduce step per cycle over {y_i, k zeros}, MSB first.
module mont_domain_encoder #(
    parameter int DATA_LENGTH = 32
) (
    input  logic                   CLK_pci_sys_clk_p,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [DATA_LENGTH-1:0] y_i,
    input  logic [DATA_LENGTH-1:0] m_i,
    input  logic [DATA_LENGTH-1:0] m_bl_i,
    output logic                   busy_o,
    output logic [DATA_LENGTH-1:0] result_o,
    output logic                   valid_o
);

    localparam int CW = $clog2(2 * DATA_LENGTH + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state;
    logic [DATA_LENGTH:0]   acc;
    logic [DATA_LENGTH-1:0] y_sh;
    logic [DATA_LENGTH-1:0] m_q;
    logic [CW-1:0]          cnt;

    logic [DATA_LENGTH+1:0] t_w;
    logic [DATA_LENGTH+1:0] m_ext;
    logic [DATA_LENGTH+1:0] red_w;
    logic [DATA_LENGTH:0]   acc_nxt;
    logic                   last_step;
    logic                   accept;
    logic [CW-1:0]          n_steps;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        t_w     = {acc, y_sh[DATA_LENGTH-1]};
        m_ext   = {2'b00, m_q};
        red_w   = (t_w >= m_ext) ? (t_w - m_ext) : t_w;
        acc_nxt = red_w[DATA_LENGTH:0];
    end

    assign last_step = (state == RUN) && (cnt == CW'(1));
    assign accept    = start_i && ((state == IDLE) || last_step);

    // An out-of-range k is clamped so an illegal job still finishes in 2*DATA_LENGTH steps.
    assign n_steps = (m_bl_i > DATA_LENGTH'(DATA_LENGTH))
                   ? CW'(2 * DATA_LENGTH)
                   : CW'(DATA_LENGTH) + m_bl_i[CW-1:0];

    // NOTE: sequential state uses non-blocking assignments only; later ones win on the same edge.
    always_ff @(posedge CLK_pci_sys_clk_p) begin
        if (rst_i) begin
            state    <= IDLE;
            acc      <= '0;
            y_sh     <= '0;
            m_q      <= '0;
            cnt      <= '0;
            busy_o   <= 1'b0;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            valid_o <= 1'b0;

            if (state == RUN) begin
                acc  <= acc_nxt;
                y_sh <= {y_sh[DATA_LENGTH-2:0], 1'b0};
                cnt  <= cnt - CW'(1);
                if (last_step) begin
                    result_o <= acc_nxt[DATA_LENGTH-1:0];
                    valid_o  <= 1'b1;
                end
            end

            // A start on the completing edge chains straight into the next job.
            if (accept) begin
                acc    <= '0;
                y_sh   <= y_i;
                m_q    <= m_i;
                cnt    <= n_steps;
                state  <= RUN;
                busy_o <= 1'b1;
            end else if (last_step) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mont_domain_encoder.sv
// Scoreboard bench for mont_domain_encoder: expected results queued at accept, checked at valid.
module tb_mont_domain_encoder;

    localparam int DL = 32;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [DL-1:0] y_i, m_i, m_bl_i;
    logic          busy_o, valid_o;
    logic [DL-1:0] result_o;

    mont_domain_encoder #(.DATA_LENGTH(DL)) dut (
        .CLK_pci_sys_clk_p(clk),
        .rst_i            (rst_i),
        .start_i          (start_i),
        .y_i              (y_i),
        .m_i              (m_i),
        .m_bl_i           (m_bl_i),
        .busy_o           (busy_o),
        .result_o         (result_o),
        .valid_o          (valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DL-1:0] res;
        int            lat;
        bit            dc;
        int            acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_i && valid_o) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 64'd1, 64'd0);
            end else begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = cyc - e.acc_cyc;
                if (e.dc) begin
                    check("illegal_bound", 64'(lat <= 2 * DL), 64'd1);
                end else begin
                    check("result", 64'(result_o), 64'(e.res));
                    check("latency", 64'(lat), 64'(e.lat));
                end
            end
        end
    end

    // Holds start_i until the DUT accepts (idle accept or chained accept on a valid edge).
    task automatic start_job(input logic [DL-1:0] y, input logic [DL-1:0] m,
                             input logic [DL-1:0] k, input bit dc);
        bit   prev_busy;
        bit   ok;
        exp_t e;
        y_i     = y;
        m_i     = m;
        m_bl_i  = k;
        start_i = 1'b1;
        ok      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            prev_busy = busy_o;
            @(posedge clk);
            #1;
            if ((!prev_busy && busy_o) || valid_o) begin
                ok = 1'b1;
                break;
            end
        end
        start_i = 1'b0;
        check("accept_timeout", 64'(ok), 64'd1);
        if (ok) begin
            e.res     = DL'(({32'b0, y} << k) % {32'b0, m});
            e.lat     = DL + int'(k);
            e.dc      = dc;
            e.acc_cyc = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy_o && sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_timeout", 64'(ok), 64'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0]   m64;
        logic [DL-1:0] k;

        rst_i   = 1'b1;
        start_i = 1'b0;
        y_i     = '0;
        m_i     = '0;
        m_bl_i  = '0;
        @(posedge clk);
        #1;
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_result", 64'(result_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;

        // Dilithium modulus, chained with no gap cycles.
        start_job(32'd1,        32'h7FE001, 32'd23, 1'b0);
        start_job(32'h7FE000,   32'h7FE001, 32'd23, 1'b0);
        start_job(32'd0,        32'h7FE001, 32'd23, 1'b0);
        wait_idle();
        check("dil_last_result", 64'(result_o), 64'h0);

        // Unreduced operand with k=0.
        start_job(32'hFFFFFFFF, 32'h7FE001, 32'd0, 1'b0);
        wait_idle();
        check("unreduced_result", 64'(result_o), 64'h3FFDFF);

        // Start during busy is ignored: only one valid, carrying the first job.
        start_job(32'd1, 32'h7FE001, 32'd23, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        y_i     = 32'h1234;
        m_i     = 32'h13;
        m_bl_i  = 32'd5;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("busy_during_job", 64'(busy_o), 64'd1);
        wait_idle();
        check("busy_ignore_result", 64'(result_o), 64'h1FFF);
        repeat (70) @(posedge clk);
        #1;
        check("busy_ignore_idle", 64'(busy_o), 64'd0);

        // Illegal k: must still complete within 2*DL cycles.
        start_job(32'h55, 32'h10, 32'd40, 1'b1);
        wait_idle();

        // Mid-operation reset with a simultaneous start request.
        start_job(32'd1, 32'h7FE001, 32'd23, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst_i   = 1'b1;
        start_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        start_i = 1'b0;
        check("mid_rst_busy", 64'(busy_o), 64'd0);
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_result", 64'(result_o), 64'd0);
        sb.delete();
        repeat (70) @(posedge clk);
        #1;
        check("mid_rst_stays_idle", 64'(busy_o), 64'd0);
        start_job(32'd1, 32'h7FE001, 32'd23, 1'b0);
        wait_idle();
        check("post_rst_result", 64'(result_o), 64'h1FFF);

        // Randomised golden runs, chained back to back.
        for (int r = 0; r < 1000; r++) begin
            k   = DL'($urandom_range(2, 32));
            m64 = ({32'b0, $urandom} | (64'd1 << (k - 1)) | 64'd1) & ((64'd1 << k) - 64'd1);
            start_job($urandom, m64[DL-1:0], k, 1'b0);
        end
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mont_domain_encoder.md
# mont_domain_encoder

Serial converter that maps an operand into Montgomery form, y_mont = y·2^k mod m with k = m_bl_i. It produces the y operand consumed by montgomery_serialized; that multiplier yields (x·y_mont·2^-k) mod m = x·y mod m. It uses the same start/valid handshake and the same m_i / m_bl_i operand convention, so both blocks can share the modulus source from params_pkg.

## Interface
- DATA_LENGTH, default 32: operand width, in bits, of y_i, m_i, m_bl_i and result_o.
- CLK_pci_sys_clk_p  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- start_i  input  1  request a conversion; sampled only in IDLE.
- y_i  input  DATA_LENGTH  operand; any value, including y_i ≥ m_i.
- m_i  input  DATA_LENGTH  modulus; must be odd and > 1.
- m_bl_i  input  DATA_LENGTH  exponent k; legal range 0..DATA_LENGTH; m_i < 2^k required when k > 0.
- busy_o  output  1  high while a conversion is in progress.
- result_o  output  DATA_LENGTH  y·2^k mod m; held until the next completion or reset.
- valid_o  output  1  one-cycle pulse marking result_o as new.

## Operation
- Algorithm: left-to-right shift-and-reduce over the bit string {y_i[DATA_LENGTH-1:0], k zeros}, MSB first.
  - Per step: t = 2·acc + bit; acc ← (t ≥ m) ? t − m : t.
  - acc is DATA_LENGTH+1 bits wide; the invariant acc < m always holds.
- Step count N = DATA_LENGTH + k. Because the y bits are fed through the same loop, y ≥ m is reduced automatically.
- State machine:
  - IDLE: when start_i=1, latch y_i, m_i and k into internal registers, clear acc, load counter = N, go to RUN.
  - RUN: one step per cycle and counter decrements. On the last step, write the final acc to result_o, pulse valid_o, return to IDLE.
- Inputs are used only on the accept edge; they may change freely afterwards.
- start_i in RUN is ignored. There is no queueing.
- Illegal inputs (k > DATA_LENGTH, even m, m ≤ 1): result_o is undefined, but the handshake must still complete in at most 2·DATA_LENGTH cycles and return to IDLE. It must never hang.
- Reset: state ← IDLE, acc and counter ← 0. Outputs reset to busy_o=0, valid_o=0, result_o=0.

## Timing
- Accept edge E0 is the edge where the state is IDLE and start_i=1. busy_o is 1 from E0.
- Edges E1..EN each perform one step. At EN: result_o updates, valid_o=1, busy_o=0, state=IDLE.
- valid_o is high for exactly the cycle between EN and EN+1. Start-to-valid latency is N cycles (DATA_LENGTH for k=0).
- Back-to-back: start_i=1 sampled at EN is accepted; it becomes the new E0 and raises busy_o again. valid_o still drops at EN+1, and result_o holds the old value until the new completion.
- Reset during RUN: at the reset edge, busy_o=0, valid_o=0 and result_o=0. No valid pulse is issued for the aborted job. start_i asserted together with rst_i is ignored.
- Reset has priority over every other event on the same edge.

## Test plan
- Dilithium modulus: m=0x7FE001 (8380417), k=23, y=1 → result_o=0x001FFF, valid pulse exactly 55 cycles after the accept edge, busy_o high for those 55 cycles.
- Same m and k, y=0x7FE000 (m−1) → 0x7FC002; y=0 → 0x000000. Each job is started on its predecessor's valid edge, with no gap cycles.
- Unreduced operand, k=0: y=0xFFFFFFFF, m=0x7FE001 → 0x3FFDFF after 32 cycles.
- Randomised golden check: 1000 runs with random y, random odd m with bit length k in 2..32, compared against (y·2^k) % m computed in a 64-bit bench model. All results match and every latency equals 32+k.
- Start during busy: pulse start_i with new operands 5 cycles into a job → exactly one valid pulse, carrying the original job's result.
- Mid-operation reset: assert rst_i for 1 cycle 10 cycles into the k=23 job → busy_o, valid_o and result_o all read 0 on the next cycle, with no valid pulse. A fresh start afterwards produces the correct 0x001FFF.
